sample_dma_scheduler: RTL and testbench
=======================================

# sample_dma_scheduler

Sequences the sample info fetcher through one round of sample slots per audio frame and turns each valid slot into one 256-byte DMA read request. Starts the fetcher on `frame_tick`, consumes its `sample_*` outputs, and issues requests over a valid/ready handshake. Waits for DMA completion, then pulses `load_next_sample`, and ends the round on the last slot or on a scan timeout. Sits between the fetcher and the DMA read engine inside the sampler DMA unit.

## Interface
- `SAMPLE_ID_WIDTH`, 6: width of slot id; matches fetcher BRAM address width.
- `SCAN_TIMEOUT`, 256: cycles allowed in WAIT_SAMPLE without `sample_valid` before the round is aborted.
- `clk` in 1: single clock.
- `reset_n` in 1: reset is synchronous and active-low.
- `enable` in 1: level; permits new rounds.
- `frame_tick` in 1: one-cycle pulse; requests a new round.
- `clear_status` in 1: pulse; clears sticky flags.
- `fetch_start` out 1: one-cycle pulse to the fetcher `start` input.
- `fetch_stop` out 1: one-cycle pulse to the fetcher `stop` input; resets the fetcher slot pointer to 0.
- `sample_addr` in 32: current slot address from the fetcher.
- `sample_id` in `SAMPLE_ID_WIDTH`: current slot id from the fetcher.
- `sample_valid` in 1: current slot valid from the fetcher.
- `sample_last` in 1: current slot is the last one in the loop.
- `sample_overflow` in 1: current slot address is exhausted.
- `load_next_sample` out 1: one-cycle pulse; advances the fetcher.
- `all_samples_invalid` out 1: one-cycle pulse on scan timeout.
- `dma_req_valid` out 1: DMA request valid.
- `dma_req_ready` in 1: DMA request ready.
- `dma_req_addr` out 32: captured `sample_addr`.
- `dma_req_id` out `SAMPLE_ID_WIDTH`: captured `sample_id`.
- `dma_done` in 1: pulse; the outstanding transfer finished.
- `dma_error` in 1: qualified by `dma_done`; the transfer failed.
- `busy` out 1: high in any state other than IDLE.
- `round_done` out 1: one-cycle pulse at the end of each round.
- `issued_count` out `SAMPLE_ID_WIDTH+1`: number of DMA requests issued in the last completed round.
- `round_overrun` out 1: sticky; `frame_tick` arrived while `busy`.
- `dma_err` out 1: sticky; `dma_done && dma_error` was seen.

## Operation
- Moore FSM. Every pulse/level output is decoded from the registered state or from registered flags.
- **IDLE:** `enable && frame_tick` -> START. Otherwise stay.
- **START:** assert `fetch_start`, clear the round issue counter and the scan timer -> WAIT_SAMPLE.
- **WAIT_SAMPLE:**
  - First cycle after ADVANCE is a guard cycle: `sample_valid` is ignored.
  - `~enable` -> ROUND_END.
  - `sample_valid` -> capture addr, id, `last` and `overflow` into registers.
    - Captured overflow set -> ADVANCE; no request is issued.
    - Otherwise -> REQ.
  - Otherwise the scan timer increments. Timer reaching `SCAN_TIMEOUT-1` -> pulse `all_samples_invalid`, -> ROUND_END.
- **REQ:**
  - `dma_req_valid=1`; addr and id are held stable.
  - `dma_req_ready` -> issue counter +1 -> WAIT_DONE.
  - Once asserted, `dma_req_valid` is never withdrawn, even if `enable` drops.
- **WAIT_DONE:**
  - `dma_done` -> ADVANCE.
  - `dma_error` with `dma_done` sets `dma_err`; the round continues.
- **ADVANCE:** pulse `load_next_sample`, clear the scan timer.
  - Captured last, or `~enable` -> ROUND_END.
  - Otherwise -> WAIT_SAMPLE.
- **ROUND_END:** pulse `fetch_stop` and `round_done`, latch the issue counter into `issued_count` -> IDLE.
- `frame_tick` while `busy` sets `round_overrun`; the tick is dropped, not queued.
- `clear_status` clears `round_overrun` and `dma_err`. A set event in the same cycle wins.
- Issue counter saturates at 2^`SAMPLE_ID_WIDTH`.

## Timing
- Reset: state IDLE. All outputs 0, including `issued_count`, both sticky flags and the captured registers.
- Reset mid-round returns to IDLE in the next cycle with no `fetch_stop` pulse. The fetcher shares the same reset.
- `frame_tick` (cycle N) -> `fetch_start` at N+1 -> WAIT_SAMPLE from N+2.
- `sample_valid` sampled at cycle M -> `dma_req_valid` at M+1.
- Handshake at cycle K -> WAIT_DONE from K+1. A `dma_done` arriving at K is ignored; the DMA engine never completes in the handshake cycle.
- `dma_done` at D -> `load_next_sample` at D+1.
- Minimum per-slot cost: 4 cycles plus DMA latency.
- `round_done` and `fetch_stop` are coincident. `issued_count` is valid from the cycle after `round_done`.

## Structure
- Package `sampler_dma_pkg`:
  - state enum.
  - `DMA_XFER_BYTES = 32'h100`.
  - `SAMPLE_ID_WIDTH` default.
- Sub-module `sample_scan_timer`: a loadable up-counter with clear, enable and terminal-count output, used for the WAIT_SAMPLE timeout.

## Test plan
- **Three valid slots, last flag on slot 2, DMA ready immediately, done 10 cycles after handshake:** exactly 3 requests, at addrs 0x1000, 0x2000, 0x3000 with ids 0/1/2; 3 `load_next_sample` pulses; `round_done` once; `issued_count=3`.
- **`dma_req_ready` held low 20 cycles:** `dma_req_valid`, addr and id stay stable for all 20 cycles; a single handshake follows.
- **No `sample_valid` for 256 cycles:** `all_samples_invalid` and `fetch_stop` pulse; `issued_count=0`; returns to IDLE.
- **Slot 1 has `sample_overflow=1`:** no request for id 1; `load_next_sample` still pulses; `issued_count=2` of 3 slots.
- **`frame_tick` during WAIT_DONE, then `enable` dropped in REQ:** `round_overrun=1`; the request completes its handshake and done; then ROUND_END; `clear_status` returns `round_overrun` to 0.
- **`dma_done`+`dma_error` on slot 0:** `dma_err=1`; the round continues to the last slot; `reset_n=0` mid-round returns all outputs to 0 within 1 cycle.

Source files
------------

// File: rtl/sample_dma_scheduler_pkg.sv
// Shared types and constants for the sampler DMA scheduler.
// Slot ids follow the fetcher BRAM address width.
package sampler_dma_pkg;

   localparam int DEF_SAMPLE_ID_WIDTH = 6;
   localparam int DEF_SCAN_TIMEOUT    = 256;
   localparam logic [31:0] DMA_XFER_BYTES = 32'h100;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_WAIT_SAMPLE,
      S_REQ,
      S_WAIT_DONE,
      S_ADVANCE,
      S_ROUND_END
   } sched_state_t;

   function automatic logic state_busy(sched_state_t s);
      return s != S_IDLE;
   endfunction

endpackage

// File: rtl/sample_dma_scheduler_if.sv
// Request/completion handshake between the scheduler and
// the DMA read engine.
interface sample_dma_scheduler_if
   import sampler_dma_pkg::*;
#(
   parameter int SAMPLE_ID_WIDTH = DEF_SAMPLE_ID_WIDTH
);

   logic                       dma_req_valid;
   logic                       dma_req_ready;
   logic [31:0]                dma_req_addr;
   logic [SAMPLE_ID_WIDTH-1:0] dma_req_id;
   logic                       dma_done;
   logic                       dma_error;

   modport master (
      output dma_req_valid,
      output dma_req_addr,
      output dma_req_id,
      input  dma_req_ready,
      input  dma_done,
      input  dma_error
   );

   modport slave (
      input  dma_req_valid,
      input  dma_req_addr,
      input  dma_req_id,
      output dma_req_ready,
      output dma_done,
      output dma_error
   );

endinterface

// File: rtl/sample_dma_scheduler_scan_timer.sv
// Loadable up-counter with clear/enable; tc flags the last
// count before the scan window expires.
module sample_scan_timer #(
   parameter int TERMINAL = 256,
   parameter int WIDTH    = $clog2(TERMINAL) + 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             en,
   output logic             tc
);

   localparam logic [WIDTH-1:0] TC_VAL = WIDTH'(TERMINAL - 1);

   logic [WIDTH-1:0] count;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (en) begin
         count <= count + 1'b1;
      end
   end

   assign tc = (count == TC_VAL);

endmodule

// File: rtl/sample_dma_scheduler.sv
// Walks the fetcher through one round of sample slots per
// frame, issuing one DMA read per valid slot.
module sample_dma_scheduler
   import sampler_dma_pkg::*;
#(
   parameter int SAMPLE_ID_WIDTH = DEF_SAMPLE_ID_WIDTH,
   parameter int SCAN_TIMEOUT    = DEF_SCAN_TIMEOUT
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       enable,
   input  logic                       frame_tick,
   input  logic                       clear_status,
   output logic                       fetch_start,
   output logic                       fetch_stop,
   input  logic [31:0]                sample_addr,
   input  logic [SAMPLE_ID_WIDTH-1:0] sample_id,
   input  logic                       sample_valid,
   input  logic                       sample_last,
   input  logic                       sample_overflow,
   output logic                       load_next_sample,
   output logic                       all_samples_invalid,
   sample_dma_scheduler_if.master     dma,
   output logic                       busy,
   output logic                       round_done,
   output logic [SAMPLE_ID_WIDTH:0]   issued_count,
   output logic                       round_overrun,
   output logic                       dma_err
);

   localparam int CW = SAMPLE_ID_WIDTH + 1;
   localparam logic [CW-1:0] CNT_MAX = {1'b1, {SAMPLE_ID_WIDTH{1'b0}}};
   localparam int TW = $clog2(SCAN_TIMEOUT) + 1;

   sched_state_t               state;
   logic                       guard;
   logic                       cap_last;
   logic [31:0]                req_addr;
   logic [SAMPLE_ID_WIDTH-1:0] req_id;
   logic [CW-1:0]              issue_cnt;
   logic                       asi_q;

   logic slot_hit;
   logic tmr_clear;
   logic tmr_en;
   logic tmr_tc;

   // The guard cycle hides stale fetcher data right after an advance.
   assign slot_hit  = sample_valid && !guard;
   assign tmr_clear = (state == S_START) || (state == S_ADVANCE);
   assign tmr_en    = (state == S_WAIT_SAMPLE) && enable && !slot_hit;

   sample_scan_timer #(
      .TERMINAL (SCAN_TIMEOUT),
      .WIDTH    (TW)
   ) u_timer (
      .clk        (clk),
      .reset_n    (reset_n),
      .clear      (tmr_clear),
      .load       (1'b0),
      .load_value ('0),
      .en         (tmr_en),
      .tc         (tmr_tc)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state         <= S_IDLE;
         guard         <= 1'b0;
         cap_last      <= 1'b0;
         req_addr      <= '0;
         req_id        <= '0;
         issue_cnt     <= '0;
         issued_count  <= '0;
         asi_q         <= 1'b0;
         round_overrun <= 1'b0;
         dma_err       <= 1'b0;
      end else begin
         asi_q <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (enable && frame_tick) begin
                  state <= S_START;
               end
            end
            S_START: begin
               issue_cnt <= '0;
               guard     <= 1'b0;
               state     <= S_WAIT_SAMPLE;
            end
            S_WAIT_SAMPLE: begin
               guard <= 1'b0;
               if (!enable) begin
                  state <= S_ROUND_END;
               end else if (slot_hit) begin
                  req_addr <= sample_addr;
                  req_id   <= sample_id;
                  cap_last <= sample_last;
                  state    <= sample_overflow ? S_ADVANCE : S_REQ;
               end else if (tmr_tc) begin
                  asi_q <= 1'b1;
                  state <= S_ROUND_END;
               end
            end
            S_REQ: begin
               if (dma.dma_req_ready) begin
                  if (issue_cnt != CNT_MAX) begin
                     issue_cnt <= issue_cnt + 1'b1;
                  end
                  state <= S_WAIT_DONE;
               end
            end
            S_WAIT_DONE: begin
               if (dma.dma_done) begin
                  state <= S_ADVANCE;
               end
            end
            S_ADVANCE: begin
               if (cap_last || !enable) begin
                  state <= S_ROUND_END;
               end else begin
                  guard <= 1'b1;
                  state <= S_WAIT_SAMPLE;
               end
            end
            S_ROUND_END: begin
               issued_count <= issue_cnt;
               state        <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase

         // Set beats clear when both land in the same cycle.
         if (frame_tick && state_busy(state)) begin
            round_overrun <= 1'b1;
         end else if (clear_status) begin
            round_overrun <= 1'b0;
         end

         if ((state == S_WAIT_DONE) && dma.dma_done && dma.dma_error) begin
            dma_err <= 1'b1;
         end else if (clear_status) begin
            dma_err <= 1'b0;
         end
      end
   end

   assign fetch_start         = (state == S_START);
   assign fetch_stop          = (state == S_ROUND_END);
   assign round_done          = (state == S_ROUND_END);
   assign load_next_sample    = (state == S_ADVANCE);
   assign busy                = state_busy(state);
   assign all_samples_invalid = asi_q;
   assign dma.dma_req_valid   = (state == S_REQ);
   assign dma.dma_req_addr    = req_addr;
   assign dma.dma_req_id      = req_id;

endmodule

// File: tb/tb_sample_dma_scheduler.sv
// Directed bench for sample_dma_scheduler with a fetcher model,
// a DMA responder and a request scoreboard.
module tb_sample_dma_scheduler;
   import sampler_dma_pkg::*;

   localparam int W = 6;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset_n, enable, frame_tick, clear_status;
   logic          fetch_start, fetch_stop, load_next_sample;
   logic          all_samples_invalid, busy, round_done;
   logic          round_overrun, dma_err;
   logic [31:0]   sample_addr;
   logic [W-1:0]  sample_id;
   logic          sample_valid, sample_last, sample_overflow;
   logic [W:0]    issued_count;

   sample_dma_scheduler_if #(.SAMPLE_ID_WIDTH(W)) dma ();

   sample_dma_scheduler #(
      .SAMPLE_ID_WIDTH (W),
      .SCAN_TIMEOUT    (256)
   ) dut (
      .clk                 (clk),
      .reset_n             (reset_n),
      .enable              (enable),
      .frame_tick          (frame_tick),
      .clear_status        (clear_status),
      .fetch_start         (fetch_start),
      .fetch_stop          (fetch_stop),
      .sample_addr         (sample_addr),
      .sample_id           (sample_id),
      .sample_valid        (sample_valid),
      .sample_last         (sample_last),
      .sample_overflow     (sample_overflow),
      .load_next_sample    (load_next_sample),
      .all_samples_invalid (all_samples_invalid),
      .dma                 (dma.master),
      .busy                (busy),
      .round_done          (round_done),
      .issued_count        (issued_count),
      .round_overrun       (round_overrun),
      .dma_err             (dma_err)
   );

   typedef struct {
      logic [31:0]  addr;
      logic [W-1:0] id;
   } req_t;

   req_t exp_q[$];

   int n_cmp  = 0;
   int n_fail = 0;
   int n_req  = 0;
   int n_load = 0;
   int n_round = 0;
   int n_asi  = 0;

   logic [31:0]  slot_addr [8];
   logic [W-1:0] slot_id   [8];
   logic         slot_ovf  [8];
   logic         slot_last [8];
   int           n_slots = 0;

   logic         err_en = 1'b0;
   logic [W-1:0] err_id = '0;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Fetcher model: slot pointer driven by start/stop/load_next.
   initial begin
      int  ptr;
      logic active;
      ptr = 0;
      active = 1'b0;
      sample_addr = '0;
      sample_id = '0;
      sample_valid = 1'b0;
      sample_last = 1'b0;
      sample_overflow = 1'b0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            active = 1'b0;
            ptr = 0;
         end else begin
            if (fetch_stop) begin
               active = 1'b0;
               ptr = 0;
            end
            if (fetch_start) begin
               active = 1'b1;
               ptr = 0;
            end
            if (load_next_sample) ptr++;
         end
         if (active && ptr < n_slots) begin
            sample_valid    = 1'b1;
            sample_addr     = slot_addr[ptr];
            sample_id       = slot_id[ptr];
            sample_overflow = slot_ovf[ptr];
            sample_last     = slot_last[ptr];
         end else begin
            sample_valid    = 1'b0;
            sample_addr     = '0;
            sample_id       = '0;
            sample_overflow = 1'b0;
            sample_last     = 1'b0;
         end
      end
   end

   // DMA responder: done ten cycles after each handshake.
   initial begin
      int cnt;
      logic [W-1:0] cur_id;
      cnt = 0;
      cur_id = '0;
      dma.dma_done = 1'b0;
      dma.dma_error = 1'b0;
      forever begin
         @(negedge clk);
         dma.dma_done = 1'b0;
         dma.dma_error = 1'b0;
         if (!reset_n) begin
            cnt = 0;
         end else begin
            if (cnt > 0) begin
               cnt--;
               if (cnt == 0) begin
                  dma.dma_done = 1'b1;
                  dma.dma_error = err_en && (cur_id == err_id);
               end
            end
            if (dma.dma_req_valid && dma.dma_req_ready) begin
               cnt = 10;
               cur_id = dma.dma_req_id;
            end
         end
      end
   end

   // Scoreboard and pulse counters.
   always @(negedge clk) begin
      if (reset_n === 1'b1) begin
         if (dma.dma_req_valid && dma.dma_req_ready) begin
            if (exp_q.size() == 0) begin
               chk("req_unexpected", 1, 0);
            end else begin
               req_t e;
               e = exp_q.pop_front();
               chk("req_addr", dma.dma_req_addr, e.addr);
               chk("req_id", dma.dma_req_id, e.id);
            end
            n_req++;
         end
         if (load_next_sample) n_load++;
         if (round_done) n_round++;
         if (all_samples_invalid) n_asi++;
         if (fetch_stop || round_done)
            chk("stop_vs_round", fetch_stop, round_done);
      end
   end

   task automatic set_slot(input int i, input logic [31:0] a,
                           input logic [W-1:0] id,
                           input logic ovf, input logic last);
      slot_addr[i] = a;
      slot_id[i]   = id;
      slot_ovf[i]  = ovf;
      slot_last[i] = last;
   endtask

   task automatic push_exp(input logic [31:0] a, input logic [W-1:0] id);
      req_t e;
      e.addr = a;
      e.id = id;
      exp_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk); #1 frame_tick = 1'b1;
      @(posedge clk); #1 frame_tick = 1'b0;
   endtask

   task automatic wait_round(input int budget, output int cycles);
      logic seen;
      seen = 1'b0;
      cycles = 0;
      while (!seen && cycles < budget) begin
         @(negedge clk);
         cycles++;
         if (round_done) seen = 1'b1;
      end
      chk("round_done_seen", seen, 1);
   endtask

   task automatic wait_valid(input int budget, input logic need_ready);
      logic seen;
      int c;
      seen = 1'b0;
      c = 0;
      while (!seen && c < budget) begin
         @(negedge clk);
         c++;
         if (dma.dma_req_valid && (!need_ready || dma.dma_req_ready))
            seen = 1'b1;
      end
      chk("req_seen", seen, 1);
   endtask

   initial begin
      int cyc, b_req, b_load, b_round, b_asi;
      reset_n = 1'b0;
      enable = 1'b0;
      frame_tick = 1'b0;
      clear_status = 1'b0;
      dma.dma_req_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_fetch_start", fetch_start, 0);
      chk("rst_fetch_stop", fetch_stop, 0);
      chk("rst_load_next", load_next_sample, 0);
      chk("rst_asi", all_samples_invalid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_round_done", round_done, 0);
      chk("rst_issued", issued_count, 0);
      chk("rst_overrun", round_overrun, 0);
      chk("rst_dma_err", dma_err, 0);
      chk("rst_req_valid", dma.dma_req_valid, 0);
      chk("rst_req_addr", dma.dma_req_addr, 0);
      chk("rst_req_id", dma.dma_req_id, 0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      enable = 1'b1;

      // Three valid slots, last on slot 2.
      set_slot(0, 32'h1000, 0, 0, 0);
      set_slot(1, 32'h2000, 1, 0, 0);
      set_slot(2, 32'h3000, 2, 0, 1);
      n_slots = 3;
      push_exp(32'h1000, 0);
      push_exp(32'h2000, 1);
      push_exp(32'h3000, 2);
      dma.dma_req_ready = 1'b1;
      b_req = n_req; b_load = n_load; b_round = n_round;
      tick();
      @(negedge clk);
      chk("t1_fetch_start", fetch_start, 1);
      chk("t1_busy", busy, 1);
      wait_round(300, cyc);
      @(negedge clk); #1;
      chk("t1_issued", issued_count, 3);
      chk("t1_idle", busy, 0);
      chk("t1_reqs", n_req - b_req, 3);
      chk("t1_loads", n_load - b_load, 3);
      chk("t1_rounds", n_round - b_round, 1);
      chk("t1_q_empty", exp_q.size(), 0);

      // Ready held low for 20 cycles.
      set_slot(0, 32'h4000, 5, 0, 1);
      n_slots = 1;
      push_exp(32'h4000, 5);
      dma.dma_req_ready = 1'b0;
      b_req = n_req;
      tick();
      wait_valid(20, 1'b0);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("t2_valid_hold", dma.dma_req_valid, 1);
         chk("t2_addr_hold", dma.dma_req_addr, 32'h4000);
         chk("t2_id_hold", dma.dma_req_id, 5);
      end
      @(posedge clk); #1 dma.dma_req_ready = 1'b1;
      wait_round(100, cyc);
      @(negedge clk); #1;
      chk("t2_reqs", n_req - b_req, 1);
      chk("t2_issued", issued_count, 1);

      // No valid slot: scan timeout.
      n_slots = 0;
      b_req = n_req; b_asi = n_asi;
      tick();
      wait_round(400, cyc);
      chk("t3_timeout_cycles", cyc, 258);
      chk("t3_asi_pulse", all_samples_invalid, 1);
      @(negedge clk); #1;
      chk("t3_asi_count", n_asi - b_asi, 1);
      chk("t3_issued", issued_count, 0);
      chk("t3_reqs", n_req - b_req, 0);
      chk("t3_idle", busy, 0);

      // Slot 1 overflowed.
      set_slot(0, 32'h1000, 0, 0, 0);
      set_slot(1, 32'h2000, 1, 1, 0);
      set_slot(2, 32'h3000, 2, 0, 1);
      n_slots = 3;
      push_exp(32'h1000, 0);
      push_exp(32'h3000, 2);
      b_req = n_req; b_load = n_load;
      tick();
      wait_round(300, cyc);
      @(negedge clk); #1;
      chk("t4_reqs", n_req - b_req, 2);
      chk("t4_loads", n_load - b_load, 3);
      chk("t4_issued", issued_count, 2);

      // Overrun tick in WAIT_DONE, enable dropped in REQ.
      set_slot(0, 32'h5000, 0, 0, 0);
      set_slot(1, 32'h6000, 1, 0, 0);
      set_slot(2, 32'h7000, 2, 0, 1);
      n_slots = 3;
      push_exp(32'h5000, 0);
      push_exp(32'h6000, 1);
      b_req = n_req; b_load = n_load;
      tick();
      wait_valid(20, 1'b1);
      @(posedge clk); #1;
      frame_tick = 1'b1;
      dma.dma_req_ready = 1'b0;
      @(posedge clk); #1 frame_tick = 1'b0;
      wait_valid(40, 1'b0);
      @(posedge clk); #1 enable = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t5_valid_kept", dma.dma_req_valid, 1);
      end
      @(posedge clk); #1 dma.dma_req_ready = 1'b1;
      wait_round(100, cyc);
      @(negedge clk); #1;
      chk("t5_overrun", round_overrun, 1);
      chk("t5_reqs", n_req - b_req, 2);
      chk("t5_loads", n_load - b_load, 2);
      chk("t5_issued", issued_count, 2);
      @(posedge clk); #1 clear_status = 1'b1;
      @(posedge clk); #1 clear_status = 1'b0;
      @(negedge clk);
      chk("t5_overrun_clr", round_overrun, 0);
      enable = 1'b1;

      // DMA error on slot 0, then reset mid-round.
      set_slot(0, 32'h1000, 0, 0, 0);
      set_slot(1, 32'h2000, 1, 0, 0);
      set_slot(2, 32'h3000, 2, 0, 1);
      n_slots = 3;
      push_exp(32'h1000, 0);
      push_exp(32'h2000, 1);
      push_exp(32'h3000, 2);
      err_en = 1'b1;
      err_id = 0;
      b_req = n_req;
      tick();
      wait_round(300, cyc);
      @(negedge clk); #1;
      chk("t6_dma_err", dma_err, 1);
      chk("t6_reqs", n_req - b_req, 3);
      chk("t6_issued", issued_count, 3);
      err_en = 1'b0;
      dma.dma_req_ready = 1'b0;
      tick();
      wait_valid(20, 1'b0);
      @(posedge clk); #1 reset_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("t6_rst_busy", busy, 0);
      chk("t6_rst_valid", dma.dma_req_valid, 0);
      chk("t6_rst_addr", dma.dma_req_addr, 0);
      chk("t6_rst_id", dma.dma_req_id, 0);
      chk("t6_rst_issued", issued_count, 0);
      chk("t6_rst_dma_err", dma_err, 0);
      chk("t6_rst_fetch_stop", fetch_stop, 0);
      chk("t6_rst_round_done", round_done, 0);
      @(posedge clk); #1 reset_n = 1'b1;
      repeat (2) @(posedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_fail);
      $finish;
   end

endmodule
